pipe_stage: RTL



---
 rtl/pipe_stage_pkg.sv | 12 +
 rtl/pipe_stage.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the pipe_stage boundary register: FSM state encoding
// for the main/skid entry pair.
package pipe_stage_pkg;

   // Encoding equals the number of held words, so occupancy is the state itself.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_stage.sv
// Pipeline boundary register with valid/ready handshake, synchronous flush and
// an optional skid entry that keeps in_ready registered at full throughput.
module pipe_stage
   import pipe_stage_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter bit               SKID      = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   logic r_rdy_en;
   logic w_in_xfer;
   logic w_out_xfer;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_rdy_en <= 1'b0;
      else          r_rdy_en <= 1'b1;
   end

   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = out_valid & out_ready;

   generate
      if (SKID == 1'b0) begin : g_single
         logic             r_valid;
         logic [WIDTH-1:0] r_main;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_valid <= 1'b0;
               r_main  <= RESET_VAL;
            end else if (flush) begin
               r_valid <= 1'b0;
               r_main  <= RESET_VAL;
            end else if (w_in_xfer) begin
               r_valid <= 1'b1;
               r_main  <= in_data;
            end else if (w_out_xfer) begin
               r_valid <= 1'b0;
            end
         end

         assign in_ready  = r_rdy_en & (~r_valid | out_ready);
         assign out_valid = r_valid;
         assign out_data  = r_main;
         assign occupancy = {1'b0, r_valid};
      end else begin : g_skid
         state_t           r_state;
         logic             r_valid;
         logic             r_in_ready;
         logic [WIDTH-1:0] r_main;
         logic [WIDTH-1:0] r_skid;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_state    <= ST_EMPTY;
               r_valid    <= 1'b0;
               r_in_ready <= 1'b0;
               r_main     <= RESET_VAL;
               r_skid     <= RESET_VAL;
            end else if (flush) begin
               r_state    <= ST_EMPTY;
               r_valid    <= 1'b0;
               r_in_ready <= 1'b1;
               r_main     <= RESET_VAL;
               r_skid     <= RESET_VAL;
            end else begin
               // in_ready is the registered image of "next state is not FULL".
               r_in_ready <= 1'b1;
               case (r_state)
                  ST_EMPTY: begin
                     if (w_in_xfer) begin
                        r_main  <= in_data;
                        r_valid <= 1'b1;
                        r_state <= ST_BUSY;
                     end
                  end
                  ST_BUSY: begin
                     if (w_in_xfer && w_out_xfer) begin
                        r_main <= in_data;
                     end else if (w_in_xfer) begin
                        r_skid     <= in_data;
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b0;
                     end else if (w_out_xfer) begin
                        r_valid <= 1'b0;
                        r_state <= ST_EMPTY;
                     end
                  end
                  ST_FULL: begin
                     if (w_out_xfer) begin
                        r_main  <= r_skid;
                        r_state <= ST_BUSY;
                     end else begin
                        r_in_ready <= 1'b0;
                     end
                  end
                  default: begin
                     r_state <= ST_EMPTY;
                     r_valid <= 1'b0;
                  end
               endcase
            end
         end

         assign in_ready  = r_rdy_en & r_in_ready;
         assign out_valid = r_valid;
         assign out_data  = r_main;
         assign occupancy = r_state;
      end
   endgenerate

endmodule
